// File: rtl/ext_align_pipe_pkg.sv
// ext_align_pipe_pkg
//   Shared types for the load-path extender: access size codes and the
//   occupancy states of the output register / skid buffer pair.
package ext_align_pipe_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_FULL = 2'b11
   } sz_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } st_e;

   // Number of bytes a size code selects from a word of nb bytes.
   function automatic int size_bytes(input sz_e sz, input int nb);
      case (sz)
         SZ_BYTE: size_bytes = 1;
         SZ_HALF: size_bytes = 2;
         SZ_WORD: size_bytes = 4;
         default: size_bytes = nb;
      endcase
   endfunction

endpackage

// File: rtl/ext_align_pipe_if.sv
// ext_align_pipe_if
//   Handshake bundle for ext_align_pipe.
//   Input side : in_valid/in_ready, in_word, in_ofs, in_size, in_signed, in_tag
//   Output side: out_valid/out_ready, out_data, out_err, out_tag
//   slave  : the extender's view
//   master : the producer/consumer view around it
interface ext_align_pipe_if #(
   parameter int WORD_W = 32,
   parameter int OUT_W  = 32,
   parameter int TAG_W  = 5,
   localparam int NB    = WORD_W / 8,
   localparam int OFS_W = $clog2(NB)
) ();

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_word;
   logic [OFS_W-1:0]  in_ofs;
   logic [1:0]        in_size;
   logic              in_signed;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_err;
   logic [TAG_W-1:0]  out_tag;

   modport slave (
      input  in_valid, in_word, in_ofs, in_size, in_signed, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_err, out_tag
   );

   modport master (
      output in_valid, in_word, in_ofs, in_size, in_signed, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_err, out_tag
   );

endinterface

// File: rtl/ext_align_pipe_core.sv
// ext_align_core
//   Combinational lane select, alignment check and zero/sign extension.
//   i_word   raw memory word
//   i_ofs    byte offset within the word
//   i_size   access size code (byte/half/word/full)
//   i_signed 1 = sign-extend, 0 = zero-extend
//   o_data   extended field, zero when misaligned
//   o_err    misaligned access
module ext_align_core
   import ext_align_pipe_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int OUT_W      = 32,
   parameter bit BIG_ENDIAN = 1'b1,
   localparam int NB        = WORD_W / 8,
   localparam int OFS_W     = $clog2(NB)
) (
   input  logic [WORD_W-1:0] i_word,
   input  logic [OFS_W-1:0]  i_ofs,
   input  logic [1:0]        i_size,
   input  logic              i_signed,
   output logic [OUT_W-1:0]  o_data,
   output logic              o_err
);

   logic [7:0]        w_lane [NB];
   logic [WORD_W-1:0] w_field;
   logic [OUT_W-1:0]  w_mask;
   logic              w_sign;
   logic              w_misalign;
   int                w_nbytes;
   int                w_ofs;

   for (genvar g = 0; g < NB; g++) begin : g_lane
      if (BIG_ENDIAN) begin : g_be
         assign w_lane[g] = i_word[8*(NB-1-g) +: 8];
      end else begin : g_le
         assign w_lane[g] = i_word[8*g +: 8];
      end
   end

   assign w_nbytes = size_bytes(sz_e'(i_size), NB);
   assign w_ofs    = int'(i_ofs);

   // Assemble the field least-significant byte first. Every index is a loop
   // constant, so the variable offset becomes a plain mux per byte.
   always_comb begin
      w_field = '0;
      w_mask  = '0;
      w_sign  = 1'b0;
      for (int j = 0; j < NB; j++) begin
         if (j < w_nbytes) begin
            for (int i = 0; i < NB; i++) begin
               if ((BIG_ENDIAN  && i == w_ofs + w_nbytes - 1 - j) ||
                   (!BIG_ENDIAN && i == w_ofs + j)) begin
                  w_field[8*j +: 8] = w_lane[i];
               end
            end
            w_mask[8*j +: 8] = 8'hFF;
            if (j == w_nbytes - 1) begin
               w_sign = w_field[8*j + 7];
            end
         end
      end
   end

   // The range check also covers word widths that are not a power-of-two
   // number of bytes, where an aligned word access could run off the end.
   always_comb begin
      case (sz_e'(i_size))
         SZ_HALF: w_misalign = i_ofs[0];
         SZ_WORD: w_misalign = |i_ofs[1:0];
         SZ_FULL: w_misalign = |i_ofs;
         default: w_misalign = 1'b0;
      endcase
      if (w_ofs + w_nbytes > NB) begin
         w_misalign = 1'b1;
      end
   end

   // With a full-width access and OUT_W == WORD_W the mask covers every bit,
   // so ~w_mask is zero and i_signed has no effect.
   always_comb begin
      o_err  = w_misalign;
      o_data = '0;
      if (!w_misalign) begin
         o_data = OUT_W'(w_field) | ((i_signed && w_sign) ? ~w_mask : '0);
      end
   end

endmodule

// File: rtl/ext_align_pipe.sv
// ext_align_pipe
//   Registered load-path extender with valid/ready handshake, one cycle of
//   latency and a one-entry skid so in_ready never depends on out_ready.
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   bus    ext_align_pipe_if.slave (input item and output result handshakes)
//
//   state    | meaning
//   ST_EMPTY | nothing held, output invalid
//   ST_ONE   | one result in the output register
//   ST_FULL  | output register and skid both hold a result, in_ready low
module ext_align_pipe
   import ext_align_pipe_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int OUT_W      = 32,
   parameter int TAG_W      = 5,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input logic             clk,
   input logic             reset,
   ext_align_pipe_if.slave bus
);

   logic [OUT_W-1:0] w_ext_data;
   logic             w_ext_err;
   logic             w_accept;
   logic             w_pop;

   st_e              r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_err;
   logic [TAG_W-1:0] r_out_tag;
   logic [OUT_W-1:0] r_skid_data;
   logic             r_skid_err;
   logic [TAG_W-1:0] r_skid_tag;

   // Extension happens before storage, so the skid holds finished results
   // and only one core is needed.
   ext_align_core #(
      .WORD_W     (WORD_W),
      .OUT_W      (OUT_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_core (
      .i_word   (bus.in_word),
      .i_ofs    (bus.in_ofs),
      .i_size   (bus.in_size),
      .i_signed (bus.in_signed),
      .o_data   (w_ext_data),
      .o_err    (w_ext_err)
   );

   assign w_accept = bus.in_valid & r_in_ready;
   assign w_pop    = r_out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_err   <= 1'b0;
         r_out_tag   <= '0;
         r_skid_data <= '0;
         r_skid_err  <= 1'b0;
         r_skid_tag  <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_out_data  <= w_ext_data;
                  r_out_err   <= w_ext_err;
                  r_out_tag   <= bus.in_tag;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_pop) begin
                  r_out_data <= w_ext_data;
                  r_out_err  <= w_ext_err;
                  r_out_tag  <= bus.in_tag;
               end else if (w_accept) begin
                  r_skid_data <= w_ext_data;
                  r_skid_err  <= w_ext_err;
                  r_skid_tag  <= bus.in_tag;
                  r_in_ready  <= 1'b0;
                  r_state     <= ST_FULL;
               end else if (w_pop) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  r_out_data <= r_skid_data;
                  r_out_err  <= r_skid_err;
                  r_out_tag  <= r_skid_tag;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_err   = r_out_err;
   assign bus.out_tag   = r_out_tag;

endmodule

// File: tb/tb_ext_align_pipe.sv
module tb_ext_align_pipe;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ext_align_pipe_if #(.WORD_W(32), .OUT_W(32), .TAG_W(5)) b32 ();
   ext_align_pipe_if #(.WORD_W(64), .OUT_W(64), .TAG_W(5)) b64 ();

   ext_align_pipe #(.WORD_W(32), .OUT_W(32), .TAG_W(5), .BIG_ENDIAN(1'b1)) u_dut32 (
      .clk   (clk),
      .reset (reset),
      .bus   (b32)
   );

   ext_align_pipe #(.WORD_W(64), .OUT_W(64), .TAG_W(5), .BIG_ENDIAN(1'b0)) u_dut64 (
      .clk   (clk),
      .reset (reset),
      .bus   (b64)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic chk32(input string name, input logic v, input logic [31:0] d,
                        input logic e, input logic [4:0] t);
      chk({name, ".valid"}, 64'(b32.out_valid), 64'(v));
      chk({name, ".data"},  64'(b32.out_data),  64'(d));
      chk({name, ".err"},   64'(b32.out_err),   64'(e));
      chk({name, ".tag"},   64'(b32.out_tag),   64'(t));
   endtask

   task automatic chk64(input string name, input logic [63:0] d, input logic e, input logic [4:0] t);
      chk({name, ".valid"}, 64'(b64.out_valid), 64'd1);
      chk({name, ".data"},  b64.out_data,       d);
      chk({name, ".err"},   64'(b64.out_err),   64'(e));
      chk({name, ".tag"},   64'(b64.out_tag),   64'(t));
   endtask

   task automatic drv32(input logic v, input logic [31:0] w, input logic [1:0] o,
                        input logic [1:0] s, input logic sg, input logic [4:0] t);
      b32.in_valid  = v;
      b32.in_word   = w;
      b32.in_ofs    = o;
      b32.in_size   = s;
      b32.in_signed = sg;
      b32.in_tag    = t;
   endtask

   task automatic drv64(input logic v, input logic [63:0] w, input logic [2:0] o,
                        input logic [1:0] s, input logic sg, input logic [4:0] t);
      b64.in_valid  = v;
      b64.in_word   = w;
      b64.in_ofs    = o;
      b64.in_size   = s;
      b64.in_signed = sg;
      b64.in_tag    = t;
   endtask

   initial begin
      reset         = 1'b1;
      b32.out_ready = 1'b0;
      b64.out_ready = 1'b1;
      drv32(1'b0, 32'h0, 2'd0, 2'b00, 1'b0, 5'd0);
      drv64(1'b0, 64'h0, 3'd0, 2'b00, 1'b0, 5'd0);
      step();
      step();
      reset = 1'b0;
      chk32("reset", 1'b0, 32'h0, 1'b0, 5'd0);
      chk("reset.in_ready", 64'(b32.in_ready), 64'd1);
      step();
      chk("idle.in_ready", 64'(b32.in_ready), 64'd1);

      // byte lanes, big-endian, signed then unsigned
      b32.out_ready = 1'b1;
      drv32(1'b1, 32'h12F4_80FF, 2'd2, 2'b00, 1'b1, 5'd7);
      step();
      chk32("byte_s", 1'b1, 32'hFFFF_FF80, 1'b0, 5'd7);
      drv32(1'b1, 32'h12F4_80FF, 2'd2, 2'b00, 1'b0, 5'd8);
      step();
      chk32("byte_u", 1'b1, 32'h0000_0080, 1'b0, 5'd8);

      // halves, word, full, misalignment
      drv32(1'b1, 32'h8001_7FFE, 2'd0, 2'b01, 1'b1, 5'd9);
      step();
      chk32("half0_s", 1'b1, 32'hFFFF_8001, 1'b0, 5'd9);
      drv32(1'b1, 32'h8001_7FFE, 2'd2, 2'b01, 1'b1, 5'd10);
      step();
      chk32("half2_s", 1'b1, 32'h0000_7FFE, 1'b0, 5'd10);
      drv32(1'b1, 32'h8001_7FFE, 2'd1, 2'b01, 1'b1, 5'd11);
      step();
      chk32("half1_err", 1'b1, 32'h0, 1'b1, 5'd11);
      drv32(1'b1, 32'h8001_7FFE, 2'd0, 2'b10, 1'b1, 5'd12);
      step();
      chk32("word0", 1'b1, 32'h8001_7FFE, 1'b0, 5'd12);
      drv32(1'b1, 32'h8001_7FFE, 2'd2, 2'b11, 1'b0, 5'd13);
      step();
      chk32("full2_err", 1'b1, 32'h0, 1'b1, 5'd13);
      drv32(1'b1, 32'h8001_7FFE, 2'd3, 2'b00, 1'b1, 5'd14);
      step();
      chk32("byte3_s", 1'b1, 32'hFFFF_FFFE, 1'b0, 5'd14);
      drv32(1'b0, 32'h0, 2'd0, 2'b00, 1'b0, 5'd0);
      step();
      chk32("drain_hold", 1'b0, 32'hFFFF_FFFE, 1'b0, 5'd14);

      // backpressure fills the skid, then drains in order
      b32.out_ready = 1'b0;
      drv32(1'b1, 32'h0000_0001, 2'd3, 2'b00, 1'b0, 5'd1);
      chk("bp.rdy1", 64'(b32.in_ready), 64'd1);
      step();
      chk32("bp.one", 1'b1, 32'd1, 1'b0, 5'd1);
      drv32(1'b1, 32'h0000_0002, 2'd3, 2'b00, 1'b0, 5'd2);
      chk("bp.rdy2", 64'(b32.in_ready), 64'd1);
      step();
      drv32(1'b1, 32'h0000_0003, 2'd3, 2'b00, 1'b0, 5'd3);
      chk("bp.rdy3", 64'(b32.in_ready), 64'd0);
      chk32("bp.full", 1'b1, 32'd1, 1'b0, 5'd1);
      step();
      chk32("bp.stall", 1'b1, 32'd1, 1'b0, 5'd1);
      chk("bp.rdy_stall", 64'(b32.in_ready), 64'd0);
      b32.out_ready = 1'b1;
      step();
      chk32("bp.pop2", 1'b1, 32'd2, 1'b0, 5'd2);
      chk("bp.rdy_back", 64'(b32.in_ready), 64'd1);
      step();
      drv32(1'b0, 32'h0, 2'd0, 2'b00, 1'b0, 5'd0);
      chk32("bp.pop3", 1'b1, 32'd3, 1'b0, 5'd3);
      step();
      chk("bp.empty", 64'(b32.out_valid), 64'd0);

      // streaming at one item per cycle
      for (int i = 0; i < 10; i++) begin
         drv32(1'b1, 32'(i + 16), 2'd3, 2'b00, 1'b0, 5'(i + 16));
         chk($sformatf("stream%0d.rdy", i), 64'(b32.in_ready), 64'd1);
         step();
         chk32($sformatf("stream%0d", i), 1'b1, 32'(i + 16), 1'b0, 5'(i + 16));
      end
      drv32(1'b0, 32'h0, 2'd0, 2'b00, 1'b0, 5'd0);
      step();
      chk("stream.end", 64'(b32.out_valid), 64'd0);

      // reset while full drops both held items
      b32.out_ready = 1'b0;
      drv32(1'b1, 32'h0000_0014, 2'd3, 2'b00, 1'b0, 5'd20);
      step();
      drv32(1'b1, 32'h0000_0015, 2'd3, 2'b00, 1'b0, 5'd21);
      step();
      drv32(1'b0, 32'h0, 2'd0, 2'b00, 1'b0, 5'd0);
      chk("rst.full_rdy", 64'(b32.in_ready), 64'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk32("rst_full", 1'b0, 32'h0, 1'b0, 5'd0);
      chk("rst_full.rdy", 64'(b32.in_ready), 64'd1);
      b32.out_ready = 1'b1;
      step();
      chk32("rst_nostale1", 1'b0, 32'h0, 1'b0, 5'd0);
      step();
      chk32("rst_nostale2", 1'b0, 32'h0, 1'b0, 5'd0);

      // 64-bit little-endian instance
      drv64(1'b1, 64'h8877_6655_4433_2211, 3'd4, 2'b10, 1'b0, 5'd1);
      step();
      chk64("le.word4_u", 64'h0000_0000_8877_6655, 1'b0, 5'd1);
      drv64(1'b1, 64'h8877_6655_4433_2211, 3'd4, 2'b10, 1'b1, 5'd2);
      step();
      chk64("le.word4_s", 64'hFFFF_FFFF_8877_6655, 1'b0, 5'd2);
      drv64(1'b1, 64'h8877_6655_4433_2211, 3'd2, 2'b01, 1'b1, 5'd3);
      step();
      chk64("le.half2", 64'h0000_0000_0000_4433, 1'b0, 5'd3);
      drv64(1'b1, 64'h8877_6655_4433_2211, 3'd0, 2'b11, 1'b1, 5'd4);
      step();
      chk64("le.full0", 64'h8877_6655_4433_2211, 1'b0, 5'd4);
      drv64(1'b1, 64'h8877_6655_4433_2211, 3'd4, 2'b11, 1'b0, 5'd5);
      step();
      chk64("le.full4_err", 64'h0, 1'b1, 5'd5);
      drv64(1'b1, 64'h8877_6655_4433_2211, 3'd2, 2'b10, 1'b0, 5'd6);
      step();
      chk64("le.word2_err", 64'h0, 1'b1, 5'd6);
      drv64(1'b1, 64'h8877_6655_4433_2211, 3'd7, 2'b00, 1'b1, 5'd7);
      step();
      chk64("le.byte7_s", 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 5'd7);
      drv64(1'b0, 64'h0, 3'd0, 2'b00, 1'b0, 5'd0);
      step();
      chk("le.end", 64'(b64.out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
